// File: rtl/eq_detect_pipe.sv
// Pipelined masked equality/zero detector with a log2 OR-reduction tree,
// valid tracking, a saturating hit counter and a sticky miss flag.
module eq_detect_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vdd,
  input  logic             vss,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] mask,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             out,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             miss_sticky
);

  localparam int D = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Supply rails are carried on the port list only.
  logic unused_rails;
  assign unused_rails = vdd ^ vss;

  function automatic logic [WIDTH-1:0] diff_vec(input logic [1:0] m,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] mk);
    return (m[0] ? a : (a ^ b)) & mk;
  endfunction

  // Pair-wise OR; zero padding above the vector makes an odd tail pass through.
  function automatic logic [WIDTH-1:0] pair_or(input logic [WIDTH-1:0] v);
    logic [2*WIDTH-1:0] pad;
    logic [WIDTH-1:0]   r;
    pad = {{WIDTH{1'b0}}, v};
    r   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = pad[2*i] | pad[2*i+1];
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [WIDTH-1:0] red_p  [0:D];
  logic [1:0]       mode_p [0:D];
  logic [D:0]       vld_p;

  // Stage 0 captures the masked difference; stages 1..D halve it each cycle.
  always_ff @(posedge clk) begin
    red_p[0]  <= diff_vec(mode, A, B, mask);
    mode_p[0] <= mode;
    for (int k = 1; k <= D; k++) begin
      red_p[k]  <= pair_or(red_p[k-1]);
      mode_p[k] <= mode_p[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p <= {vld_p[D-1:0], in_valid};
    end
  end

  // Final stage: polarity by mode; out holds across bubbles.
  logic any_p;
  assign any_p = |red_p[D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= 1'b0;
    end else begin
      out_valid <= vld_p[D];
      if (vld_p[D]) begin
        out <= mode_p[D][1] ? any_p : ~any_p;
      end
    end
  end

  // Monitor stage: clear takes effect before this cycle's event is applied.
  logic             hit_ev;
  logic             miss_ev;
  logic [CNT_W-1:0] hit_base;
  logic             miss_base;

  always_comb begin
    hit_ev    = out_valid & out;
    miss_ev   = out_valid & ~out;
    hit_base  = cnt_clr ? '0 : hit_cnt;
    miss_base = cnt_clr ? 1'b0 : miss_sticky;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt     <= '0;
      miss_sticky <= 1'b0;
    end else begin
      hit_cnt     <= hit_ev ? sat_inc(hit_base) : hit_base;
      miss_sticky <= miss_base | miss_ev;
    end
  end

endmodule

// File: tb/tb_eq_detect_pipe.sv
// Directed and small randomised checks of eq_detect_pipe at WIDTH 16 and 5,
// including counter saturation at CNT_W=2 and asynchronous reset.
module tb_eq_detect_pipe;

  localparam logic [1:0] EQ = 2'b00;
  localparam logic [1:0] ZR = 2'b01;
  localparam logic [1:0] NE = 2'b10;
  localparam logic [1:0] NZ = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vdd = 1'b1;
  logic        vss = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        in_valid = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] A = '0, B = '0, mask = '0;
  logic        ov, o, ms;
  logic [7:0]  hc;
  logic        ov_s, o_s, ms_s;
  logic [1:0]  hc_s;

  logic        in_valid5 = 1'b0;
  logic [1:0]  mode5 = 2'b00;
  logic [4:0]  A5 = '0, B5 = '0, mask5 = '0;
  logic        ov5, o5, ms5;
  logic [7:0]  hc5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eq_detect_pipe #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .vdd(vdd), .vss(vss), .in_valid(in_valid), .mode(mode),
    .A(A), .B(B), .mask(mask), .cnt_clr(cnt_clr), .out_valid(ov), .out(o),
    .hit_cnt(hc), .miss_sticky(ms));

  eq_detect_pipe #(.WIDTH(16), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .vdd(vdd), .vss(vss), .in_valid(in_valid), .mode(mode),
    .A(A), .B(B), .mask(mask), .cnt_clr(cnt_clr), .out_valid(ov_s), .out(o_s),
    .hit_cnt(hc_s), .miss_sticky(ms_s));

  eq_detect_pipe #(.WIDTH(5), .CNT_W(8)) dut5 (
    .clk(clk), .rst(rst), .vdd(vdd), .vss(vss), .in_valid(in_valid5), .mode(mode5),
    .A(A5), .B(B5), .mask(mask5), .cnt_clr(cnt_clr), .out_valid(ov5), .out(o5),
    .hit_cnt(hc5), .miss_sticky(ms5));

  task automatic drive16(input logic v, input logic [1:0] m, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] mk);
    in_valid = v; mode = m; A = a; B = b; mask = mk;
  endtask

  task automatic drive5(input logic v, input logic [1:0] m, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] mk);
    in_valid5 = v; mode5 = m; A5 = a; B5 = b; mask5 = mk;
  endtask

  function automatic logic ref_cmp(input logic [1:0] m, input logic [15:0] a,
                                   input logic [15:0] b, input logic [15:0] mk);
    logic equal;
    if (m[0]) equal = ((a & mk) == 16'h0);
    else      equal = ((a & mk) == (b & mk));
    return m[1] ? ~equal : equal;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL reset_out: got %b want 0", o); end
    checks++; if (hc !== 8'd0) begin errors++; $display("FAIL reset_hit_cnt: got %0d want 0", hc); end
    checks++; if (ms !== 1'b0) begin errors++; $display("FAIL reset_miss: got %b want 0", ms); end
    checks++; if (ov5 !== 1'b0) begin errors++; $display("FAIL reset_out_valid5: got %b want 0", ov5); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_latency();
    drive16(1'b1, EQ, 16'h1234, 16'h1234, 16'hFFFF);
    @(negedge clk);
    drive16(1'b0, EQ, 16'h0, 16'h0, 16'h0);
    for (int i = 1; i <= 5; i++) begin
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL latency_early edge %0d: out_valid=%b want 0", i, ov); end
      @(negedge clk);
    end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL latency_valid: out_valid=%b want 1", ov); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL latency_out: out=%b want 1", o); end
    @(negedge clk);
    checks++; if (hc !== 8'd1) begin errors++; $display("FAIL latency_hit_cnt: got %0d want 1", hc); end
    checks++; if (ms !== 1'b0) begin errors++; $display("FAIL latency_miss: got %b want 0", ms); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL latency_single: out_valid=%b want 0", ov); end
  endtask

  task automatic test_back_to_back_modes();
    logic exp_o [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    drive16(1'b1, EQ, 16'h00F0, 16'h00F1, 16'hFFFF); @(negedge clk);
    drive16(1'b1, EQ, 16'h00F0, 16'h00F1, 16'hFFFE); @(negedge clk);
    drive16(1'b1, ZR, 16'h0000, 16'hFFFF, 16'hFFFF); @(negedge clk);
    drive16(1'b1, NZ, 16'h8000, 16'hFFFF, 16'hFFFF); @(negedge clk);
    drive16(1'b0, EQ, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL modes_valid[%0d]: got %b want 1", i, ov); end
      checks++; if (o !== exp_o[i]) begin errors++; $display("FAIL modes_out[%0d]: got %b want %b", i, o, exp_o[i]); end
    end
    @(negedge clk);
    checks++; if (ms !== 1'b1) begin errors++; $display("FAIL modes_miss: got %b want 1", ms); end
    checks++; if (hc !== 8'd4) begin errors++; $display("FAIL modes_hit_cnt: got %0d want 4", hc); end
  endtask

  task automatic test_odd_width();
    drive5(1'b1, EQ, 5'b10000, 5'b00000, 5'b11111); @(negedge clk);
    drive5(1'b1, EQ, 5'b10000, 5'b00000, 5'b01111); @(negedge clk);
    drive5(1'b0, EQ, 5'b0, 5'b0, 5'b0);
    repeat (2) @(negedge clk);
    checks++; if (ov5 !== 1'b0) begin errors++; $display("FAIL odd_early: out_valid=%b want 0", ov5); end
    @(negedge clk);
    checks++; if (ov5 !== 1'b1) begin errors++; $display("FAIL odd_valid0: got %b want 1", ov5); end
    checks++; if (o5 !== 1'b0) begin errors++; $display("FAIL odd_full_mask: out=%b want 0", o5); end
    @(negedge clk);
    checks++; if (ov5 !== 1'b1) begin errors++; $display("FAIL odd_valid1: got %b want 1", ov5); end
    checks++; if (o5 !== 1'b1) begin errors++; $display("FAIL odd_masked_top: out=%b want 1", o5); end
    @(negedge clk);
    checks++; if (ov5 !== 1'b0) begin errors++; $display("FAIL odd_tail: out_valid=%b want 0", ov5); end
    checks++; if (hc5 !== 8'd1) begin errors++; $display("FAIL odd_hit_cnt: got %0d want 1", hc5); end
    checks++; if (ms5 !== 1'b1) begin errors++; $display("FAIL odd_miss: got %b want 1", ms5); end
  endtask

  task automatic test_saturation();
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    checks++; if (hc_s !== 2'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", hc_s); end
    checks++; if (ms_s !== 1'b0) begin errors++; $display("FAIL sat_clear_miss: got %b want 0", ms_s); end
    for (int i = 0; i < 5; i++) begin
      drive16(1'b1, EQ, 16'hAAAA, 16'hAAAA, 16'hFFFF);
      @(negedge clk);
    end
    drive16(1'b0, EQ, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    checks++; if (hc_s !== 2'd0) begin errors++; $display("FAIL sat_pre: got %0d want 0", hc_s); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (hc_s !== 2'(sat_exp[i])) begin errors++; $display("FAIL sat_seq[%0d]: got %0d want %0d", i, hc_s, sat_exp[i]); end
    end
    drive16(1'b1, EQ, 16'h5555, 16'h5555, 16'hFFFF);
    @(negedge clk);
    drive16(1'b0, EQ, 16'h0, 16'h0, 16'h0);
    repeat (5) @(negedge clk);
    checks++; if (ov_s !== 1'b1 || o_s !== 1'b1) begin errors++; $display("FAIL sat_clr_hit_result: valid=%b out=%b want 1 1", ov_s, o_s); end
    cnt_clr = 1'b1;
    @(negedge clk);
    checks++; if (hc_s !== 2'd1) begin errors++; $display("FAIL sat_clr_with_hit: got %0d want 1", hc_s); end
    @(negedge clk);
    checks++; if (hc_s !== 2'd0) begin errors++; $display("FAIL sat_clr_idle: got %0d want 0", hc_s); end
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset_midflight();
    drive16(1'b1, EQ, 16'h0001, 16'h0000, 16'hFFFF);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive16(1'b1, EQ, 16'h0F0F, 16'h0F0F, 16'hFFFF);
      @(negedge clk);
    end
    drive16(1'b0, EQ, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    checks++; if (ov !== 1'b1 || o !== 1'b0) begin errors++; $display("FAIL midrst_miss_result: valid=%b out=%b want 1 0", ov, o); end
    @(negedge clk);
    checks++; if (ov !== 1'b1 || ms !== 1'b1) begin errors++; $display("FAIL midrst_pre: valid=%b miss=%b want 1 1", ov, ms); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", ov); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL midrst_out: got %b want 0", o); end
    checks++; if (hc !== 8'd0) begin errors++; $display("FAIL midrst_hit_cnt: got %0d want 0", hc); end
    checks++; if (ms !== 1'b0) begin errors++; $display("FAIL midrst_miss: got %b want 0", ms); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL midrst_flush[%0d]: out_valid=%b want 0", i, ov); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  q [$];
    logic [1:0]  e;
    logic [15:0] ra, rb, rm;
    logic [1:0]  rmd;
    logic        rv, rr;
    int          exp_h = 0;
    int          exp_hs = 0;
    logic        exp_m = 1'b0;
    for (int i = 0; i < 5; i++) q.push_back(2'b00);
    for (int n = 0; n < 406; n++) begin
      rv  = (n < 400) && ($urandom_range(0, 3) != 0);
      rmd = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 1) == 1) ? ra : 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rm = 16'h0000;
        1:       rm = 16'hFFFF;
        2:       rm = 16'($urandom);
        default: rm = 16'h0001 << $urandom_range(0, 15);
      endcase
      rr = ref_cmp(rmd, ra, rb, rm);
      drive16(rv, rmd, ra, rb, rm);
      q.push_back({rv, rr});
      @(negedge clk);
      e = q.pop_front();
      checks++; if (ov !== e[1]) begin errors++; $display("FAIL rand_valid n=%0d: got %b want %b", n, ov, e[1]); end
      if (e[1]) begin
        checks++; if (o !== e[0]) begin errors++; $display("FAIL rand_out n=%0d: got %b want %b", n, o, e[0]); end
      end
      checks++; if (hc !== 8'(exp_h)) begin errors++; $display("FAIL rand_hit_cnt n=%0d: got %0d want %0d", n, hc, exp_h); end
      checks++; if (hc_s !== 2'(exp_hs)) begin errors++; $display("FAIL rand_hit_sat n=%0d: got %0d want %0d", n, hc_s, exp_hs); end
      checks++; if (ms !== exp_m) begin errors++; $display("FAIL rand_miss n=%0d: got %b want %b", n, ms, exp_m); end
      if (e[1] && e[0]) begin
        if (exp_h < 255) exp_h++;
        if (exp_hs < 3) exp_hs++;
      end
      if (e[1] && !e[0]) exp_m = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back_modes();
    test_odd_width();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
